// File: rtl/output_port_fifo.sv
// Output-port buffer between the crossbar and a sink, valid/ready on both sides, no bypass.
// Optional drop counter on rejected offers is compiled in with OUTPUT_PORT_DROP_CNT_EN.
module output_port_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef OUTPUT_PORT_DROP_CNT_EN
  ,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  // Ready depends only on registered occupancy (and reset), never on out_ready.
  assign in_ready  = ~reset & (count_q < FULL);
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef OUTPUT_PORT_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush)
      drop_cnt_d = '0;
    else if (in_valid && !in_ready && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_output_port_fifo.sv
// Bench for output_port_fifo: directed scenarios plus random traffic against a queue model.
// Build with OUTPUT_PORT_DROP_CNT_EN defined to also check the drop counter.
module tb_output_port_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] count;
`ifdef OUTPUT_PORT_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  output_port_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
`ifdef OUTPUT_PORT_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] mq[$];
  int            m_drop = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 64'(count), 64'(mq.size()));
    check({tag, ".in_ready"}, 64'(in_ready), 64'(mq.size() < DEPTH));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
    check({tag, ".out_data"}, 64'(out_data), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
`ifdef OUTPUT_PORT_DROP_CNT_EN
    check({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
`endif
  endtask

  // Called just after a negedge: drive, take one rising edge, update model, check at next negedge.
  task automatic cycle(input string tag, input logic fl, input logic iv,
                       input logic [DW-1:0] id, input logic ordy);
    int  sz;
    bit  do_push, do_pop;
    flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    @(posedge clk);
    sz = mq.size();
    if (fl) begin
      mq.delete();
      m_drop = 0;
    end else begin
      do_push = iv && (sz < DEPTH);
      do_pop  = ordy && (sz > 0);
      if (iv && !(sz < DEPTH) && m_drop < 65535) m_drop++;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(id);
    end
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    check("rst.in_ready", 64'(in_ready), 64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_data", 64'(out_data), 64'd0);
    check("rst.count", 64'(count), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_state("post_rst");

    // single push into empty port, no bypass
    flush = 0; in_valid = 1; in_data = 8'hA1; out_ready = 1;
    #1;
    check("no_bypass.out_valid", 64'(out_valid), 64'd0);
    check("no_bypass.out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    // that edge pushed A1 (pop impossible while empty)
    mq.push_back(8'hA1);
    check_state("push_a1");
    cycle("hold_a1", 0, 0, 8'h00, 0);
    cycle("flush1", 1, 0, 8'h00, 0);

    // fill to full, fifth offer rejected
    for (int i = 1; i <= 4; i++) cycle("fill", 0, 1, 8'(i), 0);
    cycle("reject5", 0, 1, 8'h05, 0);
    cycle("hold_full", 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) cycle("drain", 0, 0, 8'h00, 1);
    cycle("drained", 0, 0, 8'h00, 1);

    // streaming: count stays at 1, pointers wrap twice
    cycle("stream0", 0, 1, 8'h10, 0);
    for (int i = 1; i < 10; i++) cycle("stream", 0, 1, 8'(8'h10 + i), 1);
    cycle("stream_tail", 0, 0, 8'h00, 1);

    // flush with a simultaneous offer
    for (int i = 0; i < 3; i++) cycle("pre_flush", 0, 1, 8'(8'h60 + i), 0);
    cycle("flush_push", 1, 1, 8'hEE, 0);
    cycle("after_flush", 0, 1, 8'h33, 0);
    cycle("after_flush2", 0, 0, 8'h00, 1);

    // asynchronous reset mid-stream with two words buffered
    cycle("pre_rst_a", 0, 1, 8'h71, 0);
    cycle("pre_rst_b", 0, 1, 8'h72, 0);
    in_valid = 0;
    #2 reset = 1'b1;
    #1;
    check("arst.count", 64'(count), 64'd0);
    check("arst.out_valid", 64'(out_valid), 64'd0);
    check("arst.out_data", 64'(out_data), 64'd0);
    check("arst.in_ready", 64'(in_ready), 64'd0);
    mq.delete();
    m_drop = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_state("arst_release");
    @(negedge clk);
    check_state("arst_idle");

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic fl, iv, ordy;
      int   bias;
      bias = (n / 100) % 3;
      fl   = ($urandom_range(0, 39) == 0);
      iv   = ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 3 : 6)));
      ordy = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 8 : 5)));
      cycle("rand", fl, iv, 8'($urandom), ordy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end
endmodule
